segway_seq: RTL and testbench
=============================

# segway_seq

Power and steering sequencer that feeds the balance math datapath. It owns the soft-start timer (`ss_tmr`), `pwr_up` and `en_steer` controls, ramping torque authority up at start and down at shutdown. It also gates steering on rider load and flags sustained over-speed. It sits between the authentication/load-cell front end and the math block, clocked by the same PID-update strobe.

## Interface
Parameters:
- `RAMP_DIV`, default 2: `vld` strobes per ±1 step of `ss_tmr` (range 1–15).
- `STEER_DLY`, default 16: consecutive qualifying `vld` strobes before steering is enabled (range 1–255).
- `FAST_LIM`, default 8: consecutive `too_fast` `vld` strobes before the alarm is raised (range 1–255).

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `vld`, in, 1: PID-update strobe; one-cycle pulse.
- `go`, in, 1: rider authorized and on board.
- `sum_gt_min`, in, 1: total load above minimum rider weight.
- `diff_gt_1_4`, in, 1: load imbalance exceeds 1/4; steering not yet allowed.
- `diff_gt_15_16`, in, 1: load imbalance exceeds 15/16; rider stepping off.
- `too_fast`, in, 1: speed-limit flag from the math block.
- `pwr_up`, out, 1: enables motor drive.
- `en_steer`, out, 1: enables steering blend.
- `ss_tmr`, out, 8: soft-start scale, unsigned; 0x00 means no torque, 0xFF means full torque.
- `ovr_spd`, out, 1: sticky over-speed alarm.
- `state`, out, 2: current state (debug).

## Operation
States and encodings: `IDLE`=0, `RAMP`=1, `BAL`=2, `DECAY`=3. `en_steer` is a flag that is valid only in `BAL`.

Prescaler `pre` (4-bit) counts `vld` strobes. In `RAMP` and `DECAY`, when `pre`==`RAMP_DIV`-1 it produces a step and clears to 0. It is cleared on every state change.

- **`IDLE`**:
  - `pwr_up`=0, `ss_tmr`=0, `en_steer`=0.
  - `go`=1 → `RAMP`.
- **`RAMP`**:
  - `pwr_up`=1.
  - Each step: `ss_tmr`++.
  - When `ss_tmr` reaches 0xFF → `BAL`. `ss_tmr` saturates at 0xFF and never wraps.
- **`BAL`**:
  - `ss_tmr` held at 0xFF.
  - Steer counter `scnt` (8-bit) increments on `vld` while `sum_gt_min` & !`diff_gt_1_4`, and clears otherwise.
  - `scnt` reaching `STEER_DLY` sets `en_steer`=1 and `scnt` saturates.
  - `en_steer` clears immediately on `vld` with !`sum_gt_min` or `diff_gt_15_16`, and `scnt` clears.
- **`DECAY`** (entered from `RAMP` or `BAL` when `go`=0, evaluated every cycle, not only on `vld`):
  - `en_steer`=0.
  - Each step: `ss_tmr`--.
  - At `ss_tmr`==0 → `IDLE`; `pwr_up` drops with the transition.
  - `go` returning to 1 in `DECAY` → `RAMP`, resuming from the current `ss_tmr` value. There is no discontinuity.
- **Simultaneous events**:
  - If `go`=0 on the same cycle as a `RAMP`→`BAL` step, `DECAY` wins.
  - In `BAL`, `go`=0 takes priority over `en_steer` set.
- **Over-speed**: see Configuration.

## Timing
- All outputs are registered.
- Reset values: `pwr_up`=0, `en_steer`=0, `ss_tmr`=0x00, `ovr_spd`=0, `state`=`IDLE`. All counters are 0.
- `go` rising in `IDLE` → `state`=`RAMP` and `pwr_up`=1 on the next clk edge.
- `ss_tmr` changes on the edge after the `vld` that completes a step. A full ramp 0→0xFF takes 255·`RAMP_DIV` `vld` strobes.
- `en_steer` asserts on the edge after the `STEER_DLY`-th qualifying `vld`. It deasserts on the edge after the disqualifying `vld`, or after `go`=0.
- `rst_n` asserted mid-operation forces reset values immediately (asynchronous). There is no decay on reset.
- `vld` held high continuously is legal: each high cycle counts as one strobe.

## Configuration
`SEGWAY_SEQ_OVRSPD_EN`:
- Defined:
  - Counter `fcnt` (8-bit) increments on `vld` while `too_fast`=1 and `pwr_up`=1, and clears on `vld` with `too_fast`=0.
  - `fcnt` reaching `FAST_LIM` sets `ovr_spd`=1 on the next edge.
  - `ovr_spd` is sticky until the state returns to `IDLE`.
  - While `ovr_spd`=1, `en_steer` is forced to 0.
- Undefined: `ovr_spd` is tied 0, `fcnt` is absent, and `too_fast` is ignored.

## Test plan
- Reset then `go`=1 with `vld` every 4 clk, `RAMP_DIV`=2 → `pwr_up`=1 one edge later; `ss_tmr` reaches 0xFF after 510 strobes; `state`=2.
- In `BAL`, `sum_gt_min`=1, `diff_gt_1_4`=0 for 16 strobes → `en_steer`=1 after the 16th. A single `diff_gt_1_4`=1 at strobe 10 restarts the count.
- In `BAL` with `en_steer`=1, pulse `diff_gt_15_16` → `en_steer`=0 next edge; `ss_tmr` stays 0xFF.
- `go`=0 at `ss_tmr`=0x80 during `RAMP` → `DECAY`, reaching 0 after 256 strobes, then `IDLE` with `pwr_up`=0. A second run re-raises `go` at `ss_tmr`=0x40 → `RAMP` continues upward from 0x40.
- With `SEGWAY_SEQ_OVRSPD_EN`, `too_fast`=1 for 7 strobes, then 0, then 8 strobes → `ovr_spd`=1 only after the 8th consecutive strobe, with `en_steer` forced 0. `ovr_spd` clears after `go`=0 decays to `IDLE`.
- Assert `rst_n`=0 mid-`RAMP` at `ss_tmr`=0x33 → all outputs return to reset values asynchronously, with no clk edge required.

Source files
------------

// File: rtl/segway_seq.sv
// Power/steering sequencer: soft-start ramp, steer gating and over-speed alarm.
// Optional over-speed alarm enabled by defining SEGWAY_SEQ_OVRSPD_EN.
module segway_seq #(
  parameter int unsigned RAMP_DIV  = 2,
  parameter int unsigned STEER_DLY = 16,
  parameter int unsigned FAST_LIM  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld,
  input  logic       go,
  input  logic       sum_gt_min,
  input  logic       diff_gt_1_4,
  input  logic       diff_gt_15_16,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic       en_steer,
  output logic [7:0] ss_tmr,
  output logic       ovr_spd,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRamp  = 2'd1,
    StBal   = 2'd2,
    StDecay = 2'd3
  } state_e;

  localparam logic [3:0] PreLast  = 4'(RAMP_DIV - 1);
  localparam logic [7:0] SteerLim = 8'(STEER_DLY);

  state_e     state_q, state_d;
  logic [3:0] pre_q, pre_d, pre_adv;
  logic [7:0] ss_q, ss_d;
  logic [7:0] scnt_q, scnt_d;
  logic       en_q, en_d;
  logic       pwr_q, pwr_d;
  logic       ovr_q, ovr_d;
  logic       step;

  assign step    = vld && (pre_q == PreLast);
  assign pre_adv = !vld ? pre_q : (step ? 4'd0 : pre_q + 4'd1);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ss_d    = ss_q;
    scnt_d  = scnt_q;
    en_d    = en_q;

    unique case (state_q)
      StIdle: begin
        ss_d   = 8'h00;
        en_d   = 1'b0;
        scnt_d = 8'h00;
        if (go) state_d = StRamp;
      end
      StRamp: begin
        en_d   = 1'b0;
        scnt_d = 8'h00;
        // Losing go beats a simultaneous ramp-complete step.
        if (!go) begin
          state_d = StDecay;
        end else if (ss_q == 8'hFF) begin
          state_d = StBal;
        end else begin
          pre_d = pre_adv;
          if (step) begin
            ss_d = ss_q + 8'd1;
            if (ss_q == 8'hFE) state_d = StBal;
          end
        end
      end
      StBal: begin
        ss_d = 8'hFF;
        if (!go) begin
          state_d = StDecay;
          en_d    = 1'b0;
          scnt_d  = 8'h00;
        end else if (vld) begin
          if (!sum_gt_min || diff_gt_15_16) begin
            en_d   = 1'b0;
            scnt_d = 8'h00;
          end else if (!diff_gt_1_4) begin
            if (scnt_q != SteerLim) scnt_d = scnt_q + 8'd1;
            if (scnt_q >= SteerLim - 8'd1) en_d = 1'b1;
          end else begin
            // Imbalance only restarts qualification; an enabled steer stays on.
            scnt_d = 8'h00;
          end
        end
      end
      StDecay: begin
        en_d   = 1'b0;
        scnt_d = 8'h00;
        if (go) begin
          state_d = StRamp;
        end else if (ss_q == 8'h00) begin
          state_d = StIdle;
        end else begin
          pre_d = pre_adv;
          if (step) begin
            ss_d = ss_q - 8'd1;
            if (ss_q == 8'h01) state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) pre_d = 4'd0;
    if (ovr_d) en_d = 1'b0;
    pwr_d = (state_d != StIdle);
  end

`ifdef SEGWAY_SEQ_OVRSPD_EN
  localparam logic [7:0] FastLim = 8'(FAST_LIM);

  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    ovr_d  = ovr_q;
    if (vld) begin
      if (!too_fast) begin
        fcnt_d = 8'h00;
      end else if (pwr_q) begin
        if (fcnt_q != FastLim) fcnt_d = fcnt_q + 8'd1;
        if (fcnt_q >= FastLim - 8'd1) ovr_d = 1'b1;
      end
    end
    // Alarm is sticky until the sequencer is back to idle.
    if (state_d == StIdle) begin
      fcnt_d = 8'h00;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= 8'h00;
    else        fcnt_q <= fcnt_d;
  end
`else
  logic unused_too_fast;
  assign unused_too_fast = too_fast;
  assign ovr_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pre_q   <= 4'd0;
      ss_q    <= 8'h00;
      scnt_q  <= 8'h00;
      en_q    <= 1'b0;
      pwr_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ss_q    <= ss_d;
      scnt_q  <= scnt_d;
      en_q    <= en_d;
      pwr_q   <= pwr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pwr_up   = pwr_q;
  assign en_steer = en_q;
  assign ss_tmr   = ss_q;
  assign ovr_spd  = ovr_q;
  assign state    = state_q;

endmodule

// File: tb/tb_segway_seq.sv
// Directed bench for segway_seq with default parameters (RAMP_DIV=2, STEER_DLY=16).
module tb_segway_seq;

  logic       clk = 1'b0;
  logic       rst_n, vld, go, sum_gt_min, diff_gt_1_4, diff_gt_15_16, too_fast;
  logic       pwr_up, en_steer, ovr_spd;
  logic [7:0] ss_tmr;
  logic [1:0] state;

  int checks = 0;
  int errs   = 0;

  segway_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .go           (go),
    .sum_gt_min   (sum_gt_min),
    .diff_gt_1_4  (diff_gt_1_4),
    .diff_gt_15_16(diff_gt_15_16),
    .too_fast     (too_fast),
    .pwr_up       (pwr_up),
    .en_steer     (en_steer),
    .ss_tmr       (ss_tmr),
    .ovr_spd      (ovr_spd),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One vld pulse every 4 clocks; returns at a negedge after the pulse took effect.
  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vld = 1'b1;
      @(negedge clk) vld = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; go = 1'b0; sum_gt_min = 1'b0;
    diff_gt_1_4 = 1'b0; diff_gt_15_16 = 1'b0; too_fast = 1'b0;
    repeat (2) tick();
    chk("rst_pwr", pwr_up, 8'd0);
    chk("rst_en", en_steer, 8'd0);
    chk("rst_ss", ss_tmr, 8'h00);
    chk("rst_ovr", ovr_spd, 8'd0);
    chk("rst_state", state, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", state, 8'd0);

    // Ramp up
    go = 1'b1;
    tick();
    chk("go_state", state, 8'd1);
    chk("go_pwr", pwr_up, 8'd1);
    strobes(1);
    chk("ramp_pre", ss_tmr, 8'h00);
    strobes(1);
    chk("ramp_step1", ss_tmr, 8'h01);
    strobes(507);
    chk("ramp_509_ss", ss_tmr, 8'hFE);
    chk("ramp_509_st", state, 8'd1);
    strobes(1);
    chk("ramp_510_ss", ss_tmr, 8'hFF);
    chk("ramp_510_st", state, 8'd2);
    chk("bal_en0", en_steer, 8'd0);

    // Steer qualification with a restart at strobe 10
    sum_gt_min = 1'b1;
    strobes(9);
    chk("steer_9", en_steer, 8'd0);
    diff_gt_1_4 = 1'b1;
    strobes(1);
    chk("steer_restart", en_steer, 8'd0);
    diff_gt_1_4 = 1'b0;
    strobes(15);
    chk("steer_15", en_steer, 8'd0);
    strobes(1);
    chk("steer_16", en_steer, 8'd1);
    strobes(3);
    chk("steer_sat", en_steer, 8'd1);

    // Step-off drops steering, torque stays full
    diff_gt_15_16 = 1'b1;
    strobes(1);
    diff_gt_15_16 = 1'b0;
    chk("stepoff_en", en_steer, 8'd0);
    chk("stepoff_ss", ss_tmr, 8'hFF);
    chk("stepoff_st", state, 8'd2);
    strobes(16);
    chk("resteer", en_steer, 8'd1);

    // go=0 in BAL: decay from 0xFF to idle
    go = 1'b0;
    tick();
    chk("bal_decay_st", state, 8'd3);
    chk("bal_decay_en", en_steer, 8'd0);
    chk("bal_decay_pwr", pwr_up, 8'd1);
    strobes(509);
    chk("decay_509_ss", ss_tmr, 8'h01);
    chk("decay_509_st", state, 8'd3);
    strobes(1);
    chk("decay_done_ss", ss_tmr, 8'h00);
    chk("decay_done_st", state, 8'd0);
    chk("decay_done_pwr", pwr_up, 8'd0);

    // Abort ramp at 0x80
    go = 1'b1;
    tick();
    strobes(256);
    chk("ramp_80", ss_tmr, 8'h80);
    go = 1'b0;
    tick();
    chk("abort_st", state, 8'd3);
    chk("abort_ss", ss_tmr, 8'h80);
    strobes(255);
    chk("abort_255", ss_tmr, 8'h01);
    strobes(1);
    chk("abort_256_ss", ss_tmr, 8'h00);
    chk("abort_256_st", state, 8'd0);
    chk("abort_256_pwr", pwr_up, 8'd0);

    // Resume from decay at 0x40
    go = 1'b1;
    tick();
    strobes(132);
    chk("ramp_42", ss_tmr, 8'h42);
    go = 1'b0;
    tick();
    strobes(4);
    chk("decay_40", ss_tmr, 8'h40);
    go = 1'b1;
    tick();
    chk("resume_st", state, 8'd1);
    chk("resume_ss", ss_tmr, 8'h40);
    strobes(2);
    chk("resume_up", ss_tmr, 8'h41);

`ifdef SEGWAY_SEQ_OVRSPD_EN
    too_fast = 1'b1;
    strobes(7);
    chk("fast_7", ovr_spd, 8'd0);
    too_fast = 1'b0;
    strobes(1);
    too_fast = 1'b1;
    strobes(7);
    chk("fast_restart7", ovr_spd, 8'd0);
    strobes(1);
    chk("fast_8", ovr_spd, 8'd1);
    chk("fast_en", en_steer, 8'd0);
    too_fast = 1'b0;
    strobes(2);
    chk("fast_sticky", ovr_spd, 8'd1);
    go = 1'b0;
    tick();
    strobes(2 * 8'h4A);
    chk("fast_idle_st", state, 8'd0);
    chk("fast_cleared", ovr_spd, 8'd0);
`else
    too_fast = 1'b1;
    strobes(12);
    chk("fast_ignored", ovr_spd, 8'd0);
    chk("fast_ramp_ss", ss_tmr, 8'h47);
    too_fast = 1'b0;
`endif

    // Asynchronous reset mid-ramp at 0x33
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    go = 1'b1;
    tick();
    strobes(2 * 8'h33);
    chk("pre_rst_ss", ss_tmr, 8'h33);
    chk("pre_rst_st", state, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwr", pwr_up, 8'd0);
    chk("arst_ss", ss_tmr, 8'h00);
    chk("arst_st", state, 8'd0);
    chk("arst_en", en_steer, 8'd0);
    chk("arst_ovr", ovr_spd, 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
